fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer for the VeriRISC processor. It generates the 3-bit phase that drives the controller, and it holds the instruction register and the program counter. It consumes the controller's ld_ir, inc_pc, ld_pc and halt strobes. It also adds run, stop, single-step and halt/resume control, so the core can be started, paused at instruction boundaries and stepped from a debug host.

## Interface
- AWIDTH, 5, width of the program counter and of the IR address field
- DWIDTH, 8, data bus and IR width; opcode is IR[DWIDTH-1:DWIDTH-3], address is IR[AWIDTH-1:0]
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  one clock; reset is asynchronous and active-low
- run_en  input  1  level; free-run request
- step  input  1  one-cycle pulse; execute exactly one instruction while stopped
- resume  input  1  one-cycle pulse; leave HALT
- data_in  input  DWIDTH  data bus; source for IR
- ld_ir, inc_pc, ld_pc, halt  input  1 each  controller strobes
- phase  output  3  current phase, to controller
- opcode  output  3  IR opcode field, to controller
- ir_addr  output  AWIDTH  IR address field, to memory address mux
- pc_addr  output  AWIDTH  program counter, to memory address mux
- halted  output  1  high while in HALT
- running  output  1  high while in RUN or STEP

## Operation
- States:
  - STOP: reset state.
  - RUN.
  - STEP.
  - HALT.
- The block is "active" when the registered state is RUN or STEP.
- When active:
  - phase increments by 1 per clock and wraps 7->0.
  - ld_ir loads data_in into IR.
  - ld_pc loads ir_addr into PC. Otherwise inc_pc increments PC modulo 2^AWIDTH. ld_pc has priority over inc_pc.
- When not active:
  - phase, IR and PC hold.
  - All controller strobes are ignored.
- Transitions (evaluated on each edge):
  - STOP: run_en=1 goes to RUN. Else step=1 goes to STEP. run_en has priority.
  - RUN: halt=1 goes to HALT. Else run_en=0 and phase==7 goes to STOP.
  - STEP: halt=1 goes to HALT. Else phase==7 goes to STOP. step pulses are ignored while in STEP.
  - HALT: resume=1 goes to RUN if run_en=1, else to STOP. step is ignored in HALT.
- Halt edge: on the edge where halt=1 while active, all strobes on that edge are still honored and phase still advances. The halt phase is 4, so phase becomes 5 and the inc_pc is applied.
- Stopping from RUN always happens at an instruction boundary: phase is 0 in STOP, except after reset mid-program.
- Reset, asynchronous and at any point including mid-instruction and mid-step:
  - state=STOP, phase=0, IR=0, PC=0.
  - opcode=0, ir_addr=0, pc_addr=0, halted=0, running=0.

## Timing
- All outputs are registered or decode directly from registers. There is no combinational path from any input to any output.
- opcode and ir_addr change on the edge after ld_ir is sampled high.
- pc_addr changes on the edge after inc_pc or ld_pc is sampled high.
- Start latency: run_en or step is sampled at edge E0 and running=1 after E0. The first phase advance is at E1. The edge that changes state does not advance phase.
- Step: exactly 8 phase advances (E1..E8), ending at phase 0 in STOP.
- Resume: sampled at edge R0 and halted=0 after R0. If run_en=1, phase advances 5->6 at R1.
- Simultaneous halt and phase==7 with run_en=0: HALT wins.

## Configuration
- Macro: FETCH_SEQ_STEP_EN.
- Defined: single-step is supported as described above.
- Undefined: the step port remains but is ignored. STEP is unreachable and STOP leaves only on run_en. The remaining behaviour is unchanged.

## Test plan
- Reset mid-run: assert rst_n=0 at phase=3, PC=9, IR=8'hA5 -> all outputs 0 immediately, without waiting for a clock edge. After release with run_en=0, phase stays 0.
- Free run with controller stub: run_en=1, data_in=8'hA5 with ld_ir at phases 2–3 and inc_pc at phase 4 -> opcode=5, ir_addr=5, pc 0->1. Phase sequence is 0..7,0 with no gaps.
- PC arithmetic:
  - PC=31 with inc_pc -> 0.
  - ld_pc and inc_pc on the same edge with ir_addr=0x12 -> PC=0x12.
- Halt/resume: halt at phase 4 -> phase=5, PC incremented, halted=1. Phase, PC and IR hold for 20 cycles despite toggled strobes. resume with run_en=1 -> halted=0, then phase=6 on the next edge.
- Single-step (FETCH_SEQ_STEP_EN defined): run_en=0, step pulse -> 8 advances ending in STOP at phase 0 with PC+1. A second step pulse mid-step is ignored. With the macro undefined, a step pulse produces no change.
- Stop at boundary: drop run_en at phase 2 -> phase continues through 7->0, then holds 0 with running=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : VeriRISC fetch sequencer. Generates the controller phase and holds
//            IR and PC. Adds run/stop/step/halt/resume control. Single-step
//            support is compiled in with the FETCH_SEQ_STEP_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    input  logic              step,
    input  logic              resume,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              halt,
    output logic [2:0]        phase,
    output logic [2:0]        opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc_addr,
    output logic              halted,
    output logic              running
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [2:0]        C_PHASE_LAST = 3'd7;
    localparam logic [AWIDTH-1:0] C_PC_ONE     = AWIDTH'(1);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_phase;
    logic [DWIDTH-1:0] r_ir;
    logic [AWIDTH-1:0] r_pc;
    logic              w_active;
    logic              w_phase_last;
    logic              w_step_req;

`ifdef FETCH_SEQ_STEP_EN
    assign w_step_req = step;
`else
    // Port kept for a uniform pinout; the request is tied off here.
    assign w_step_req = step & 1'b0;
`endif

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_phase_last = (r_phase == C_PHASE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (run_en) begin
                    w_state_next = ST_RUN;
                end else if (w_step_req) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                // Halt outranks the boundary stop on a shared edge.
                if (halt) begin
                    w_state_next = ST_HALT;
                end else if (!run_en && w_phase_last) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STEP: begin
                if (halt) begin
                    w_state_next = ST_HALT;
                end else if (w_phase_last) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_next = run_en ? ST_RUN : ST_STOP;
                end
            end
            default: w_state_next = ST_STOP;
        endcase
    end

    // Strobes on the halting edge are still honoured because w_active
    // reflects the registered state, not the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 3'd0;
            r_ir    <= '0;
            r_pc    <= '0;
        end else if (w_active) begin
            r_phase <= r_phase + 3'd1;
            if (ld_ir) begin
                r_ir <= data_in;
            end
            if (ld_pc) begin
                r_pc <= r_ir[AWIDTH-1:0];
            end else if (inc_pc) begin
                r_pc <= r_pc + C_PC_ONE;
            end
        end
    end

    assign phase   = r_phase;
    assign opcode  = r_ir[DWIDTH-1:DWIDTH-3];
    assign ir_addr = r_ir[AWIDTH-1:0];
    assign pc_addr = r_pc;
    assign halted  = (r_state == ST_HALT);
    assign running = w_active;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Randomised and directed bench for fetch_sequencer against a
//            behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int M_STOP = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_en = 1'b0, step = 1'b0, resume = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ld_ir = 1'b0, inc_pc = 1'b0, ld_pc = 1'b0, halt = 1'b0;
    logic [2:0]    phase, opcode;
    logic [AW-1:0] ir_addr, pc_addr;
    logic          halted, running;

    fetch_sequencer #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .step(step), .resume(resume),
        .data_in(data_in), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .halt(halt),
        .phase(phase), .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr),
        .halted(halted), .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mode = 0;        // 0 manual, 1 controller stub, 2 random, 3 strobe noise
    bit halt_arm = 0;
    bit cmp_en = 0;

    // Reference model state
    int m_state = M_STOP, m_phase = 0, m_ir = 0, m_pc = 0;

`ifdef FETCH_SEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    function automatic bit m_active();
        return (m_state == M_RUN) || (m_state == M_STEP);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_STOP; m_phase = 0; m_ir = 0; m_pc = 0;
        end else begin
            int nxt;
            nxt = m_state;
            case (m_state)
                M_STOP: if (run_en) nxt = M_RUN; else if (step && STEP_EN) nxt = M_STEP;
                M_RUN:  if (halt) nxt = M_HALT; else if (!run_en && m_phase == 7) nxt = M_STOP;
                M_STEP: if (halt) nxt = M_HALT; else if (m_phase == 7) nxt = M_STOP;
                default: if (resume) nxt = run_en ? M_RUN : M_STOP;
            endcase
            if (m_active()) begin
                if (ld_pc) m_pc = m_ir % (1 << AW);
                else if (inc_pc) m_pc = (m_pc + 1) % (1 << AW);
                if (ld_ir) m_ir = int'(data_in);
                m_phase = (m_phase + 1) % 8;
            end
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("phase", int'(phase), m_phase);
            chk("opcode", int'(opcode), (m_ir >> (DW - 3)) & 7);
            chk("ir_addr", int'(ir_addr), m_ir % (1 << AW));
            chk("pc_addr", int'(pc_addr), m_pc);
            chk("halted", int'(halted), int'(m_state == M_HALT));
            chk("running", int'(running), int'(m_active()));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        case (mode)
            1: begin
                ld_ir  = (m_phase == 2) || (m_phase == 3);
                inc_pc = (m_phase == 4);
                ld_pc  = 1'b0;
                halt   = halt_arm && m_active() && (m_phase == 4);
            end
            2: begin
                if ($urandom_range(15) == 0) run_en = ~run_en;
                step    = ($urandom_range(11) == 0);
                resume  = ($urandom_range(7) == 0);
                halt    = ($urandom_range(19) == 0);
                ld_ir   = ($urandom_range(2) == 0);
                inc_pc  = ($urandom_range(2) == 0);
                ld_pc   = ($urandom_range(2) == 0);
                data_in = DW'($urandom);
            end
            3: begin
                step    = $urandom_range(1) == 1;
                halt    = $urandom_range(1) == 1;
                ld_ir   = $urandom_range(1) == 1;
                inc_pc  = $urandom_range(1) == 1;
                ld_pc   = $urandom_range(1) == 1;
                data_in = DW'($urandom);
            end
            default: ;
        endcase
    endtask

    task automatic strobes_off();
        ld_ir = 0; inc_pc = 0; ld_pc = 0; halt = 0; step = 0; resume = 0;
    endtask

    task automatic wait_stop(input string nm);
        int n = 0;
        while (m_state != M_STOP && n < 40) begin cyc(); n++; end
        chk({nm, "_timeout"}, int'(n < 40), 1);
    endtask

    initial begin
        int n;
        int pc0;
        #2;
        chk("rst_phase", int'(phase), 0);
        chk("rst_running", int'(running), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1;

        // Free run with controller stub
        data_in = 8'hA5; mode = 1; run_en = 1;
        n = 0;
        while (!(m_pc == 1 && m_phase == 0) && n < 30) begin cyc(); n++; end
        chk("free_run_timeout", int'(n < 30), 1);
        chk("free_opcode", int'(opcode), 5);
        chk("free_ir_addr", int'(ir_addr), 5);
        chk("free_pc", int'(pc_addr), 1);
        chk("free_phase", int'(phase), 0);

        // Stop at instruction boundary
        n = 0;
        while (m_phase != 2 && n < 20) begin cyc(); n++; end
        run_en = 0;
        wait_stop("boundary");
        chk("boundary_phase", int'(phase), 0);
        chk("boundary_running", int'(running), 0);
        repeat (3) cyc();
        chk("boundary_hold", int'(phase), 0);

        // Halt at phase 4, hold, resume
        pc0 = m_pc;
        halt_arm = 1; run_en = 1;
        n = 0;
        while (m_state != M_HALT && n < 30) begin cyc(); n++; end
        halt_arm = 0;
        chk("halt_timeout", int'(n < 30), 1);
        chk("halt_phase", int'(phase), 5);
        chk("halt_pc", int'(pc_addr), (pc0 + 1) % 32);
        chk("halt_flag", int'(halted), 1);
        mode = 3;
        repeat (20) cyc();
        mode = 0; strobes_off();
        chk("halt_hold_phase", int'(phase), 5);
        chk("halt_hold_pc", int'(pc_addr), (pc0 + 1) % 32);
        chk("halt_hold_op", int'(opcode), 5);
        resume = 1;
        cyc();
        resume = 0;
        chk("resume_halted", int'(halted), 0);
        chk("resume_phase", int'(phase), 5);
        cyc();
        chk("resume_adv", int'(phase), 6);
        run_en = 0;
        wait_stop("resume_stop");

        // PC arithmetic
        run_en = 1; cyc();
        data_in = 8'h1F; ld_ir = 1; cyc();
        ld_ir = 0; ld_pc = 1; cyc();
        chk("pc_load31", int'(pc_addr), 31);
        ld_pc = 0; inc_pc = 1; cyc();
        chk("pc_wrap", int'(pc_addr), 0);
        inc_pc = 0; data_in = 8'h12; ld_ir = 1; cyc();
        ld_ir = 0; ld_pc = 1; inc_pc = 1; cyc();
        chk("pc_ld_prio", int'(pc_addr), 8'h12);
        strobes_off(); run_en = 0;
        wait_stop("pc_stop");

        // Single step
        pc0 = m_pc; data_in = 8'h00; mode = 1;
        step = 1; cyc(); step = 0;
        if (STEP_EN) begin
            chk("step_running", int'(running), 1);
            repeat (3) cyc();
            step = 1; cyc(); step = 0;
            wait_stop("step");
            chk("step_phase", int'(phase), 0);
            chk("step_pc", int'(pc_addr), (pc0 + 1) % 32);
            chk("step_running_end", int'(running), 0);
        end else begin
            repeat (4) cyc();
            chk("nostep_running", int'(running), 0);
            chk("nostep_phase", int'(phase), 0);
            chk("nostep_pc", int'(pc_addr), pc0);
        end

        // Randomised traffic
        mode = 2;
        repeat (1500) cyc();
        mode = 0; strobes_off(); run_en = 0;

        // Reset mid-run
        rst_n = 0; #3 rst_n = 1;
        run_en = 1; cyc();
        data_in = 8'h09; ld_ir = 1; cyc();
        ld_ir = 0; ld_pc = 1; cyc();
        ld_pc = 0; data_in = 8'hA5; ld_ir = 1; cyc();
        ld_ir = 0;
        n = 0;
        while (m_phase != 3 && n < 10) begin cyc(); n++; end
        chk("pre_rst_pc", int'(pc_addr), 9);
        chk("pre_rst_ir", int'(ir_addr), 5);
        rst_n = 0; run_en = 0;
        #1;
        chk("arst_phase", int'(phase), 0);
        chk("arst_opcode", int'(opcode), 0);
        chk("arst_ir_addr", int'(ir_addr), 0);
        chk("arst_pc", int'(pc_addr), 0);
        chk("arst_halted", int'(halted), 0);
        chk("arst_running", int'(running), 0);
        #12 rst_n = 1;
        repeat (4) cyc();
        chk("post_rst_phase", int'(phase), 0);
        chk("post_rst_running", int'(running), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
